// File: rtl/axi_bresp_tracker.sv
// AXI write-response tracker: in-order expected-ID FIFO fed by AW issues and checked
// against B-channel responses, with per-response reporting, sticky error flags and a response timeout.
module axi_bresp_tracker #(
    parameter int ID_W           = 4,
    parameter int MAX_OUT        = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         issue_valid,
    input  logic [ID_W-1:0]              issue_id,
    output logic                         issue_ready,
    input  logic [ID_W-1:0]              BID,
    input  logic [1:0]                   BRESP,
    input  logic                         BVALID,
    output logic                         BREADY,
    output logic                         resp_valid,
    output logic [ID_W-1:0]              resp_id,
    output logic [1:0]                   resp_code,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic [3:0]                   err_status,
    input  logic                         err_clear,
    output logic [1:0]                   state_out
);

    localparam int CNT_W  = $clog2(MAX_OUT + 1);
    localparam int PTR_W  = $clog2(MAX_OUT);
    localparam int TMR_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TMR_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_FAULT  = 2'b10
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [ID_W-1:0]        fifo_r [MAX_OUT];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [TMR_W-1:0]       tmr_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   iss_hs_s;
    logic                   b_hs_s;
    logic                   live_s;
    logic                   empty_s;
    logic                   pop_s;
    logic                   unexp_s;
    logic                   mism_s;
    logic                   rerr_s;
    logic                   tmo_s;
    logic                   tmr_run_s;
    logic                   clr_all_s;

    // Handshakes, error detection and next-state decode; all checks are muted while in FAULT
    always_comb begin
        issue_ready = (state_r != ST_FAULT) && (outstanding < CNT_MAX);
        iss_hs_s    = issue_valid & issue_ready;
        b_hs_s      = BVALID & BREADY;
        live_s      = (state_r != ST_FAULT);
        empty_s     = (outstanding == {CNT_W{1'b0}});
        pop_s       = live_s & b_hs_s & ~empty_s;
        unexp_s     = live_s & b_hs_s & empty_s;
        mism_s      = pop_s & (BID != fifo_r[rd_ptr_r]);
        rerr_s      = pop_s & (BRESP != 2'b00);
        tmr_run_s   = TMR_EN && (state_r == ST_ACTIVE) && !empty_s && !b_hs_s;
        tmo_s       = tmr_run_s && (tmr_r == TMR_LAST);
        clr_all_s   = (state_r == ST_FAULT) & err_clear;

        if (iss_hs_s && !pop_s) begin
            cnt_nxt_s = outstanding + 1'b1;
        end else if (pop_s && !iss_hs_s) begin
            cnt_nxt_s = outstanding - 1'b1;
        end else begin
            cnt_nxt_s = outstanding;
        end

        case (state_r)
            ST_FAULT: begin
                state_nxt_s = err_clear ? ST_IDLE : ST_FAULT;
            end
            ST_IDLE, ST_ACTIVE: begin
                if (unexp_s || mism_s || tmo_s) begin
                    state_nxt_s = ST_FAULT;
                end else if (cnt_nxt_s != {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_ACTIVE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_FAULT;
            end
        endcase
    end

    // Expected-ID storage, written at the write pointer on every accepted issue
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                fifo_r[i] <= {ID_W{1'b0}};
            end
        end else if (iss_hs_s) begin
            fifo_r[wr_ptr_r] <= issue_id;
        end else begin
            fifo_r[wr_ptr_r] <= fifo_r[wr_ptr_r];
        end
    end

    // Tracker state: FSM, pointers, counter, timer, sticky flags and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            tmr_r       <= {TMR_W{1'b0}};
            outstanding <= {CNT_W{1'b0}};
            err_status  <= 4'b0000;
            BREADY      <= 1'b0;
            resp_valid  <= 1'b0;
            resp_id     <= {ID_W{1'b0}};
            resp_code   <= 2'b00;
        end else begin
            BREADY     <= 1'b1;
            resp_valid <= b_hs_s;
            if (b_hs_s) begin
                resp_id   <= BID;
                resp_code <= BRESP;
            end

            state_r <= state_nxt_s;
            if (clr_all_s) begin
                wr_ptr_r    <= {PTR_W{1'b0}};
                rd_ptr_r    <= {PTR_W{1'b0}};
                tmr_r       <= {TMR_W{1'b0}};
                outstanding <= {CNT_W{1'b0}};
                err_status  <= 4'b0000;
            end else begin
                if (iss_hs_s) begin
                    wr_ptr_r <= wr_ptr_r + 1'b1;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + 1'b1;
                end
                outstanding <= cnt_nxt_s;
                tmr_r       <= tmr_run_s ? (tmr_r + 1'b1) : {TMR_W{1'b0}};
                // A fresh response error outranks a simultaneous clear of the same bit
                err_status  <= {err_status[3] | tmo_s,
                                err_status[2] | unexp_s,
                                err_status[1] | mism_s,
                                (err_clear ? 1'b0 : err_status[0]) | rerr_s};
            end
        end
    end

    assign state_out = state_r;

endmodule

// File: tb/tb_axi_bresp_tracker.sv
// Directed bench for axi_bresp_tracker: a scoreboard queue of expected B reports checked by
// an independent monitor, plus direct checks of counter, flags and state after each step.
module tb_axi_bresp_tracker;

    localparam int ID_W = 4;
    localparam int MOUT = 8;
    localparam int TOC  = 16;

    logic                          clk = 1'b0;
    logic                          resetn = 1'b0;
    logic                          issue_valid = 1'b0;
    logic [ID_W-1:0]               issue_id = '0;
    logic                          issue_ready;
    logic [ID_W-1:0]               BID = '0;
    logic [1:0]                    BRESP = 2'b00;
    logic                          BVALID = 1'b0;
    logic                          BREADY;
    logic                          resp_valid;
    logic [ID_W-1:0]               resp_id;
    logic [1:0]                    resp_code;
    logic [$clog2(MOUT+1)-1:0]     outstanding;
    logic [3:0]                    err_status;
    logic                          err_clear = 1'b0;
    logic [1:0]                    state_out;

    axi_bresp_tracker #(.ID_W(ID_W), .MAX_OUT(MOUT), .TIMEOUT_CYCLES(TOC)) dut (
        .clk(clk), .resetn(resetn),
        .issue_valid(issue_valid), .issue_id(issue_id), .issue_ready(issue_ready),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_code(resp_code),
        .outstanding(outstanding), .err_status(err_status),
        .err_clear(err_clear), .state_out(state_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [1:0]      code;
        int              due;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: every reported response must match the oldest expected one, on its due cycle
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("resp_unexpected_pulse", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("resp_id", int'(resp_id), int'(mon_e.id));
                chk("resp_code", int'(resp_code), int'(mon_e.code));
                chk("resp_latency_cycle", cyc, mon_e.due);
            end
        end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            chk("resp_missing", 0, 1);
        end
    end

    task automatic step(input logic iv, input logic [ID_W-1:0] iid, input logic bv,
                        input logic [ID_W-1:0] bid, input logic [1:0] br, input logic clr);
        issue_valid = iv;
        issue_id    = iid;
        BVALID      = bv;
        BID         = bid;
        BRESP       = br;
        err_clear   = clr;
        if (bv) sb_q.push_back('{id: bid, code: br, due: cyc + 1});
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        BVALID      = 1'b0;
        err_clear   = 1'b0;
    endtask

    task automatic iss(input logic [ID_W-1:0] id);
        step(1'b1, id, 1'b0, 4'd0, 2'b00, 1'b0);
    endtask

    task automatic rsp(input logic [ID_W-1:0] id, input logic [1:0] code);
        step(1'b0, 4'd0, 1'b1, id, code, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 1'b0, 4'd0, 2'b00, 1'b0);
    endtask

    task automatic clr();
        step(1'b0, 4'd0, 1'b0, 4'd0, 2'b00, 1'b1);
    endtask

    task automatic chk_st(input string tag, input int o, input int e, input int s);
        chk({tag, "_outstanding"}, int'(outstanding), o);
        chk({tag, "_err_status"}, int'(err_status), e);
        chk({tag, "_state"}, int'(state_out), s);
    endtask

    initial begin
        logic [ID_W-1:0] ids [8];
        for (int i = 0; i < 8; i++) ids[i] = ID_W'((10 + i) % 16);

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_bready", int'(BREADY), 0);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_resp_id", int'(resp_id), 0);
        chk("rst_resp_code", int'(resp_code), 0);
        chk_st("rst", 0, 0, 0);
        resetn = 1'b1;
        chk("rel_bready_low", int'(BREADY), 0);
        idle();
        chk("bready_up", int'(BREADY), 1);
        chk("idle_issue_ready", int'(issue_ready), 1);

        // Basic in-order traffic, back-to-back responses
        iss(4'd3);
        chk_st("b1", 1, 0, 1);
        iss(4'd5);
        iss(4'd7);
        chk_st("b3", 3, 0, 1);
        rsp(4'd3, 2'b00);
        chk_st("r1", 2, 0, 1);
        rsp(4'd5, 2'b00);
        chk_st("r2", 1, 0, 1);
        rsp(4'd7, 2'b00);
        chk_st("r3", 0, 0, 0);

        // Fill to MAX_OUT, blocked issue, pop frees a slot, simultaneous issue/pop, wrap
        for (int i = 0; i < 8; i++) iss(ids[i]);
        chk_st("full", 8, 0, 1);
        chk("full_issue_ready", int'(issue_ready), 0);
        iss(4'd9);
        chk("full_blocked_cnt", int'(outstanding), 8);
        rsp(ids[0], 2'b00);
        chk("pop_cnt", int'(outstanding), 7);
        chk("pop_issue_ready", int'(issue_ready), 1);
        rsp(ids[1], 2'b00);
        rsp(ids[2], 2'b00);
        rsp(ids[3], 2'b00);
        chk("cnt4", int'(outstanding), 4);
        step(1'b1, 4'd2, 1'b1, ids[4], 2'b00, 1'b0);
        chk_st("same_cycle", 4, 0, 1);
        rsp(ids[5], 2'b00);
        rsp(ids[6], 2'b00);
        rsp(ids[7], 2'b00);
        rsp(4'd2, 2'b00);
        chk_st("wrap_drain", 0, 0, 0);

        // Response error: sticky, non-fatal, cleared by err_clear; a new one beats the clear
        iss(4'd2);
        iss(4'd6);
        rsp(4'd2, 2'b10);
        chk_st("rerr", 1, 1, 1);
        clr();
        chk_st("rerr_clr", 1, 0, 1);
        rsp(4'd6, 2'b00);
        chk_st("rerr_drain", 0, 0, 0);
        iss(4'd9);
        step(1'b0, 4'd0, 1'b1, 4'd9, 2'b11, 1'b1);
        chk("rerr_wins_clear", int'(err_status), 1);
        clr();
        chk("rerr_clr2", int'(err_status), 0);

        // ID mismatch enters FAULT; FAULT blocks issues and ignores later responses
        iss(4'd1);
        iss(4'd3);
        rsp(4'd4, 2'b00);
        chk_st("mism", 1, 2, 2);
        chk("mism_issue_ready", int'(issue_ready), 0);
        iss(4'd5);
        chk("fault_blocked_cnt", int'(outstanding), 1);
        rsp(4'd7, 2'b01);
        chk_st("fault_rsp", 1, 2, 2);
        clr();
        chk_st("fault_clr", 0, 0, 0);
        chk("fault_clr_issue_ready", int'(issue_ready), 1);
        iss(4'd4);
        rsp(4'd4, 2'b00);
        chk_st("post_flush", 0, 0, 0);

        // Unexpected response with a same-cycle issue: no bypass, issue still counted
        step(1'b1, 4'd6, 1'b1, 4'd6, 2'b00, 1'b0);
        chk_st("unexp", 1, 4, 2);
        idle();
        idle();
        chk_st("unexp_hold", 1, 4, 2);
        clr();
        chk_st("unexp_clr", 0, 0, 0);

        // Timeout after TIMEOUT_CYCLES cycles of silence
        iss(4'd0);
        repeat (TOC - 1) idle();
        chk_st("pre_tmo", 1, 0, 1);
        idle();
        chk_st("tmo", 1, 8, 2);
        chk("tmo_issue_ready", int'(issue_ready), 0);

        // Asynchronous reset mid-transaction
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_bready", int'(BREADY), 0);
        chk("arst_resp_valid", int'(resp_valid), 0);
        chk_st("arst", 0, 0, 0);
        @(posedge clk);
        #1;
        chk("arst_hold_bready", int'(BREADY), 0);
        resetn = 1'b1;
        chk("arst_rel_bready", int'(BREADY), 0);
        idle();
        chk("arst_bready_up", int'(BREADY), 1);
        iss(4'd5);
        rsp(4'd5, 2'b00);
        chk_st("post_rst", 0, 0, 0);
        idle();
        idle();
        chk("sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
